// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // The add counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int CNT_W_DEFAULT = cnt_width(WIDTH_DEFAULT);

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit combinational full adder used by the serial datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: operands shift in LSB-first while load=1,
// then one bit per clock is added through a single full adder.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   SI_1,
  input  logic   SI_2,
  input  logic   load,
  output logic   Sum,
  output logic   Cy,
  output state_t dbg_state
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_inc;
  state_t           state_q;
  state_t           state_d;
  logic             fa_s;
  logic             fa_c;

  full_adder u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_c)
  );

  assign cnt_inc   = cnt_q + CW'(1);
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_LOAD, ST_ADD: state_d = (cnt_inc == LAST_CNT) ? ST_DONE : ST_ADD;
        ST_DONE:         state_d = ST_DONE;
        default:         state_d = ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_LOAD;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      Sum     <= 1'b0;
      Cy      <= 1'b0;
    end else if (load) begin
      a_q     <= {SI_1, a_q[WIDTH-1:1]};
      b_q     <= {SI_2, b_q[WIDTH-1:1]};
      carry_q <= 1'b0;
      cnt_q   <= '0;
      Sum     <= 1'b0;
      Cy      <= 1'b0;
    end else if (state_q == ST_DONE) begin
      // Operands and counter stay frozen; Cy keeps the final carry-out.
      Sum <= 1'b0;
    end else begin
      a_q     <= {1'b0, a_q[WIDTH-1:1]};
      b_q     <= {1'b0, b_q[WIDTH-1:1]};
      carry_q <= fa_c;
      cnt_q   <= cnt_inc;
      Sum     <= fa_s;
      Cy      <= fa_c;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder against an arithmetic reference model.
module tb_serial_adder;
  import serial_adder_pkg::*;

  localparam int W = 4;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   SI_1 = 1'b0;
  logic   SI_2 = 1'b0;
  logic   load = 1'b0;
  logic   Sum;
  logic   Cy;
  state_t dbg_state;

  int checks = 0;
  int errors = 0;

  // Reference model state: operand contents and add progress.
  int unsigned m_a, m_b, m_cnt, op_a, op_b;
  state_t      m_st;
  logic        e_sum, e_cy;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .SI_1      (SI_1),
    .SI_2      (SI_2),
    .load      (load),
    .Sum       (Sum),
    .Cy        (Cy),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic r, input logic ld, input logic s1, input logic s2);
    int unsigned k, mask;
    if (r) begin
      m_a = 0; m_b = 0; m_cnt = 0; m_st = ST_LOAD; e_sum = 0; e_cy = 0;
    end else if (ld) begin
      m_a = (m_a >> 1) | (int'(s1) << (W - 1));
      m_b = (m_b >> 1) | (int'(s2) << (W - 1));
      m_cnt = 0; m_st = ST_LOAD; e_sum = 0; e_cy = 0;
    end else if (m_st != ST_DONE) begin
      if (m_cnt == 0) begin
        op_a = m_a; op_b = m_b;
      end
      k     = m_cnt;
      mask  = (1 << (k + 1)) - 1;
      e_sum = 1'(((op_a + op_b) >> k) & 1);
      e_cy  = 1'((((op_a & mask) + (op_b & mask)) >> (k + 1)) & 1);
      m_a   = m_a >> 1;
      m_b   = m_b >> 1;
      m_cnt = m_cnt + 1;
      m_st  = (m_cnt == W) ? ST_DONE : ST_ADD;
    end else begin
      e_sum = 1'b0;
      e_cy  = 1'(((op_a + op_b) >> W) & 1);
    end
  endtask

  task automatic step(input logic r, input logic ld, input logic s1, input logic s2);
    rst = r; load = ld; SI_1 = s1; SI_2 = s2;
    @(posedge clk);
    model_update(r, ld, s1, s2);
    #1;
    check("sum", {7'd0, Sum}, {7'd0, e_sum});
    check("cy", {7'd0, Cy}, {7'd0, e_cy});
    check("state", {6'd0, dbg_state}, {6'd0, m_st});
  endtask

  task automatic load_ops(input logic [7:0] a, input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, a[i], b[i]);
  endtask

  // Runs W add cycles and returns {final Cy, Sum bits}.
  task automatic run_add(output logic [W:0] res);
    for (int i = 0; i < W; i++) begin
      step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      res[i] = Sum;
    end
    res[W] = Cy;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    logic [W:0] res;
    logic [7:0] ra, rb;
    m_a = 0; m_b = 0; m_cnt = 0; op_a = 0; op_b = 0;
    m_st = ST_LOAD; e_sum = 0; e_cy = 0;
    #1;

    // Reset with random inputs
    for (int i = 0; i < 2; i++)
      step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Basic: A=1011, B=0110 -> 17, then DONE holds Sum=0, Cy=1
    load_ops(8'b1011, 8'b0110, W);
    run_add(res);
    check("basic_result", 8'(res), 8'd17);
    idle(2);
    check("basic_hold_cy", {7'd0, Cy}, 8'd1);

    // All-ones -> 30
    load_ops(8'b1111, 8'b1111, W);
    run_add(res);
    check("ones_result", 8'(res), 8'd30);

    // Zero
    load_ops(8'b0000, 8'b0000, W);
    run_add(res);
    check("zero_result", 8'(res), 8'd0);

    // Over-length load keeps last W bits: A=0100, B=0
    load_ops(8'b010011, 8'b000000, 6);
    run_add(res);
    check("overlen_result", 8'(res), 8'd4);

    // Load re-asserted in the 2nd add cycle
    load_ops(8'b0111, 8'b0101, W);
    idle(1);
    load_ops(8'b1001, 8'b0011, W);
    run_add(res);
    check("abort_result", 8'(res), 8'd12);

    // Reset mid-add
    load_ops(8'b1111, 8'b0001, W);
    idle(2);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    check("midreset_sum", {7'd0, Sum}, 8'd0);
    check("midreset_cy", {7'd0, Cy}, 8'd0);

    // Randomized operands with random trailing idle cycles
    for (int t = 0; t < 24; t++) begin
      ra = 8'($urandom_range(0, (1 << W) - 1));
      rb = 8'($urandom_range(0, (1 << W) - 1));
      load_ops(ra, rb, W);
      run_add(res);
      check("rand_result", 8'(res), ra + rb);
      idle($urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial unsigned adder of two WIDTH-bit operands (default 4). Operands are shifted in LSB-first on two serial inputs while `load` is high. When `load` drops, the operands are added one bit per clock through a single full adder and a carry flip-flop. The block sits between serial data sources and a serial consumer and provides a registered sum bit stream plus the running carry.

## Interface
- WIDTH, 4, operand width in bits; must be ≥ 2.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- SI_1  input  1  serial bit of operand A, LSB first.
- SI_2  input  1  serial bit of operand B, LSB first.
- load  input  1  1 = shift operands in; 0 = add.
- Sum  output  1  registered sum bit, LSB first.
- Cy  output  1  registered carry; holds the final carry-out after WIDTH add cycles.

## Operation
- Internal state:
  - A[WIDTH-1:0], B[WIDTH-1:0]: operand shift registers.
  - carry: 1 bit.
  - cnt: add-bit counter, 0..WIDTH, width $clog2(WIDTH+1).
  - state in {LOAD, ADD, DONE}.
- rst=1 at a clock edge clears A, B, carry, cnt, Sum and Cy to 0, and sets state to LOAD. Reset overrides everything, including mid-add.
- Each edge with load=1 (any state):
  - A <= {SI_1, A[WIDTH-1:1]} and B <= {SI_2, B[WIDTH-1:1]}.
  - carry, cnt, Sum and Cy are cleared to 0.
  - state <= LOAD.
  - After WIDTH load cycles, the first bit sent is in A[0]/B[0].
  - With more than WIDTH load cycles, the last WIDTH bits are kept.
  - With fewer, the low positions keep their older contents.
- Each edge with load=0 in LOAD or ADD:
  - {c, s} = A[0] + B[0] + carry.
  - Sum <= s; carry <= c; Cy <= c.
  - A and B shift right with 0 fill.
  - cnt <= cnt+1.
  - When cnt reaches WIDTH, state <= DONE; otherwise state = ADD.
- DONE with load=0: Sum <= 0 and Cy holds the final carry. A, B and cnt are frozen.
- Asserting load in ADD or DONE aborts or ends the add and starts a new load phase. No partial-result protection.
- Arithmetic is unsigned. The full result is the WIDTH Sum bits, LSB first, plus the final Cy as bit WIDTH.

## Timing
- All outputs are registered and change only on a rising clk edge.
- Sum bit k (k=0..WIDTH-1) is valid in the cycle after the k-th load=0 edge (counting from 0).
- Cy after add edge k is the carry out of bit k. The final carry is valid after edge WIDTH-1 and is held until the next load or rst.
- Latency: WIDTH load cycles + WIDTH add cycles. The first sum bit appears one cycle after load falls.
- There is no handshake; the source must present exactly WIDTH bits while load=1.
- rst and load together: rst wins.

## Structure
- Package serial_adder_pkg holds:
  - WIDTH default constant (4).
  - state enum typedef {LOAD, ADD, DONE}.
  - counter-width localparam.
- One sub-module: full_adder (a, b, cin -> s, cout), purely combinational and instantiated once.
- Top level holds the shift registers, carry flip-flop, counter and FSM.

## Test plan
- Reset: rst=1 for 2 cycles with random inputs -> Sum=0, Cy=0, state LOAD; mid-add reset likewise returns all outputs to 0.
- Basic add: A=1011, B=0110 loaded LSB-first (SI_1: 1,1,0,1; SI_2: 0,1,1,0) -> Sum bits 1,0,0,0 and Cy sequence 0,1,1,1; final result 10001 (17). Sum=0 and Cy=1 are held afterwards.
- All-ones: A=B=1111 -> Sum bits 0,1,1,1 and final Cy=1 (30).
- Zero: A=B=0000 -> Sum 0,0,0,0 and Cy=0.
- Over-length load: 6 load cycles with SI_1 = 1,1,0,0,1,0 and SI_2 = 0 -> A=0100. Sum bits 0,0,1,0; Cy=0.
- Load re-asserted in the 2nd add cycle: carry and counter clear, the new operand loads, and the following add produces the correct new sum.
